// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared types and helpers for the APB master bridge.
//   - apb_state_e  : bridge FSM states (IDLE, SETUP, ACCESS, DONE)
//   - DEF_*        : default peripheral window (base address, region size)
//   - slave_decode : maps a byte address onto {hit, slave index}
// -----------------------------------------------------------------------------
package apb_pkg;

   // Widest address the decode helper works on; narrower buses zero-extend.
   localparam int MAX_ADDR_W = 64;
   // Index width wide enough for the largest supported slave count (16).
   localparam int SLV_IDX_W  = 4;

   localparam logic [31:0] DEF_BASE_ADDR  = 32'h1000_0000;
   localparam int          DEF_SLV_SHIFT  = 12;
   localparam int          DEF_NUM_SLAVES = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                 hit;
      logic [SLV_IDX_W-1:0] idx;
   } decode_t;

   // A miss is either below the window or past the last populated region.
   function automatic decode_t slave_decode(
      input logic [MAX_ADDR_W-1:0] addr,
      input logic [MAX_ADDR_W-1:0] base  = MAX_ADDR_W'(DEF_BASE_ADDR),
      input int unsigned           shift = DEF_SLV_SHIFT,
      input int unsigned           num   = DEF_NUM_SLAVES
   );
      logic [MAX_ADDR_W-1:0] region;
      decode_t               d;
      region = (addr - base) >> shift;
      d.hit  = (addr >= base) && (region < MAX_ADDR_W'(num));
      d.idx  = region[SLV_IDX_W-1:0];
      return d;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// -----------------------------------------------------------------------------
// apb_addr_decoder
//   Combinational slave decode for the APB master bridge.
//   Ports:
//     addr   in  ADDR_W      byte address from the core
//     hit    out 1           address falls inside a populated slave region
//     idx    out IDX_W       slave index (meaningful only when hit)
//     onehot out NUM_SLAVES  one-hot select, all zero on a miss
// -----------------------------------------------------------------------------
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                NUM_SLAVES = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
   parameter int                SLV_SHIFT  = DEF_SLV_SHIFT,
   parameter int                IDX_W      = 2
)(
   input  logic [ADDR_W-1:0]     addr,
   output logic                  hit,
   output logic [IDX_W-1:0]      idx,
   output logic [NUM_SLAVES-1:0] onehot
);

   decode_t dec;

   // NOTE: every output is assigned on every path (onehot cleared first), so no latch is inferred.
   always_comb begin
      dec    = slave_decode(MAX_ADDR_W'(addr), MAX_ADDR_W'(BASE_ADDR),
                            unsigned'(SLV_SHIFT), unsigned'(NUM_SLAVES));
      hit    = dec.hit;
      idx    = dec.idx[IDX_W-1:0];
      onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         onehot[i] = dec.hit && (dec.idx == SLV_IDX_W'(i));
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   CPU data-bus to APB master bridge. A held busReq is turned into an APB
//   SETUP/ACCESS transfer to one of NUM_SLAVES peripherals; busReady pulses for
//   one cycle when the slave completes (or at once on a decode miss, with
//   busErr set).
//
//   Build option: define APB_TIMEOUT_EN to abandon an ACCESS phase after
//   TIMEOUT_CYC wait cycles (completes with busErr=1, busRData=0). Without it
//   ACCESS waits for PREADY indefinitely.
//
//   Ports:
//     clk, reset          system clock, synchronous active-high reset
//     busReq/busWe        request level (held until busReady), 1=write
//     busAddr/busWData    byte address, write data
//     busStrb             write byte enables
//     busRData/busErr     read data and error, valid with busReady
//     busReady            one-cycle completion pulse
//     PADDR..PENABLE      APB request outputs (PADDR is the region offset)
//     PRDATA/PREADY/PSLVERR  per-slave APB responses, slave i at slice i
// -----------------------------------------------------------------------------
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                NUM_SLAVES  = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
   parameter int                SLV_SHIFT   = DEF_SLV_SHIFT,
   parameter int                TIMEOUT_CYC = 255
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         busReq,
   input  logic                         busWe,
   input  logic [ADDR_W-1:0]            busAddr,
   input  logic [DATA_W-1:0]            busWData,
   input  logic [DATA_W/8-1:0]          busStrb,
   output logic [DATA_W-1:0]            busRData,
   output logic                         busReady,
   output logic                         busErr,
   output logic [ADDR_W-1:0]            PADDR,
   output logic                         PWRITE,
   output logic [DATA_W-1:0]            PWDATA,
   output logic [DATA_W/8-1:0]          PSTRB,
   output logic [NUM_SLAVES-1:0]        PSEL,
   output logic                         PENABLE,
   input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]        PREADY,
   input  logic [NUM_SLAVES-1:0]        PSLVERR
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   apb_state_e              state;
   logic [IDX_W-1:0]        idx_q;

   logic                    dec_hit;
   logic [IDX_W-1:0]        dec_idx;
   logic [NUM_SLAVES-1:0]   dec_onehot;

   logic [ADDR_W-1:0]       paddr_off;
   logic                    ready_sel;
   logic                    slverr_sel;
   logic [DATA_W-1:0]       rdata_sel;

   apb_addr_decoder #(
      .ADDR_W     (ADDR_W),
      .NUM_SLAVES (NUM_SLAVES),
      .BASE_ADDR  (BASE_ADDR),
      .SLV_SHIFT  (SLV_SHIFT),
      .IDX_W      (IDX_W)
   ) u_dec (
      .addr   (busAddr),
      .hit    (dec_hit),
      .idx    (dec_idx),
      .onehot (dec_onehot)
   );

   // PSEL holds the latched one-hot select, so masking with it picks out the
   // active slave's handshake and ignores every other slave.
   always_comb begin
      paddr_off                    = busAddr;
      paddr_off[ADDR_W-1:SLV_SHIFT] = '0;
      ready_sel                    = |(PREADY & PSEL);
      slverr_sel                   = |(PSLVERR & PSEL);
      rdata_sel                    = PRDATA[DATA_W*int'(idx_q) +: DATA_W];
   end

   // NOTE: state and registered outputs use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the latched request fields are reset too, because they drive PADDR/PWDATA/PSTRB directly.
         state    <= IDLE;
         idx_q    <= '0;
         PADDR    <= '0;
         PWRITE   <= 1'b0;
         PWDATA   <= '0;
         PSTRB    <= '0;
         PSEL     <= '0;
         PENABLE  <= 1'b0;
         busReady <= 1'b0;
         busErr   <= 1'b0;
         busRData <= '0;
`ifdef APB_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (busReq) begin
                  if (dec_hit) begin
                     PADDR  <= paddr_off;
                     PWRITE <= busWe;
                     PWDATA <= busWData;
                     PSTRB  <= busWe ? busStrb : '0;
                     PSEL   <= dec_onehot;
                     idx_q  <= dec_idx;
                     state  <= SETUP;
                  end else begin
                     // Decode miss: answer straight away, no APB activity.
                     busReady <= 1'b1;
                     busErr   <= 1'b1;
                     busRData <= '0;
                     state    <= DONE;
                  end
               end
            end

            SETUP: begin
               PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state   <= ACCESS;
            end

            ACCESS: begin
               if (ready_sel) begin
                  PSEL     <= '0;
                  PENABLE  <= 1'b0;
                  busReady <= 1'b1;
                  busErr   <= slverr_sel;
                  busRData <= PWRITE ? '0 : rdata_sel;
                  state    <= DONE;
               end
`ifdef APB_TIMEOUT_EN
               // This cycle is the TIMEOUT_CYC-th one without PREADY.
               else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  PSEL     <= '0;
                  PENABLE  <= 1'b0;
                  busReady <= 1'b1;
                  busErr   <= 1'b1;
                  busRData <= '0;
                  state    <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end

            DONE: begin
               busReady <= 1'b0;
               busErr   <= 1'b0;
               busRData <= '0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Transaction-level model of the bridge: each request is expanded into the
//   cycle-by-cycle outputs it must produce, queued, and compared by a single
//   monitor process. Slaves are modelled by a responder with per-slave wait
//   counts, read data and error flags; unselected slaves drive random noise.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int          ADDR_W = 32;
   localparam int          DATA_W = 32;
   localparam int          NS     = 4;
   localparam int          SHIFT  = 12;
   localparam int          TO     = 8;
   localparam logic [31:0] BASE   = 32'h1000_0000;

   logic             clk = 1'b0;
   logic             reset;
   logic             busReq, busWe;
   logic [31:0]      busAddr, busWData;
   logic [3:0]       busStrb;
   logic [31:0]      busRData;
   logic             busReady, busErr;
   logic [31:0]      PADDR;
   logic             PWRITE;
   logic [31:0]      PWDATA;
   logic [3:0]       PSTRB;
   logic [NS-1:0]    PSEL;
   logic             PENABLE;
   logic [NS*32-1:0] PRDATA;
   logic [NS-1:0]    PREADY, PSLVERR;

   apb_master_bridge #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .NUM_SLAVES  (NS),
      .BASE_ADDR   (BASE),
      .SLV_SHIFT   (SHIFT),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .busReq   (busReq),
      .busWe    (busWe),
      .busAddr  (busAddr),
      .busWData (busWData),
      .busStrb  (busStrb),
      .busRData (busRData),
      .busReady (busReady),
      .busErr   (busErr),
      .PADDR    (PADDR),
      .PWRITE   (PWRITE),
      .PWDATA   (PWDATA),
      .PSTRB    (PSTRB),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR)
   );

   initial forever #5 clk = ~clk;

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Expected outputs for one cycle.
   typedef struct {
      logic [NS-1:0] psel;
      logic          penable;
      logic          pwrite;
      logic [31:0]   paddr;
      logic [31:0]   pwdata;
      logic [3:0]    pstrb;
      logic          ready;
      logic          err;
      logic [31:0]   rdata;
      bit            zero_all;
   } exp_t;

   exp_t exp_q[$];

   // Slave responder configuration.
   int          s_waits[NS];
   logic [31:0] s_rdata[NS];
   logic        s_err[NS];
   int          acc_cnt[NS];

   // Per-transaction observations used by the literal checks.
   int          m_start, m_ready_cyc, m_pen_cnt, m_pen_first;
   bit          m_ready_seen;
   logic        m_err;
   logic [31:0] m_rdata, m_paddr;
   logic [NS-1:0] m_psel_or;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic exp_t mk(input logic [NS-1:0] psel, input logic pen, input logic pw,
                               input logic [31:0] pa, input logic [31:0] pwd, input logic [3:0] ps,
                               input logic rdy, input logic err, input logic [31:0] rd,
                               input bit zero);
      exp_t e;
      e.psel = psel; e.penable = pen; e.pwrite = pw; e.paddr = pa; e.pwdata = pwd;
      e.pstrb = ps; e.ready = rdy; e.err = err; e.rdata = rd; e.zero_all = zero;
      return e;
   endfunction

   function automatic bit tb_hit(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> SHIFT) < 32'(NS));
   endfunction

   task automatic clear_mon();
      m_ready_seen = 0;
      m_ready_cyc  = -1;
      m_pen_cnt    = 0;
      m_pen_first  = -1;
      m_psel_or    = '0;
      m_paddr      = '0;
      m_err        = 1'b0;
      m_rdata      = '0;
      m_start      = cyc;
   endtask

   // Single compare process: samples 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (busReady && !m_ready_seen) begin
            m_ready_seen = 1;
            m_ready_cyc  = cyc;
            m_err        = busErr;
            m_rdata      = busRData;
         end
         if (PENABLE) begin
            m_pen_cnt++;
            if (m_pen_first < 0) m_pen_first = cyc;
         end
         m_psel_or = m_psel_or | PSEL;
         if (PSEL != '0) m_paddr = PADDR;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("PSEL", PSEL, e.psel);
            check("PENABLE", PENABLE, e.penable);
            check("busReady", busReady, e.ready);
            if (e.zero_all || e.psel != '0) begin
               check("PWRITE", PWRITE, e.pwrite);
               check("PADDR", PADDR, e.paddr);
               check("PSTRB", PSTRB, e.pstrb);
               if (e.zero_all || e.pwrite) check("PWDATA", PWDATA, e.pwdata);
            end
            if (e.zero_all || e.ready) begin
               check("busErr", busErr, e.err);
               check("busRData", busRData, e.rdata);
            end
         end
      end
   end

   // Slave responder: selected slave holds PREADY low for s_waits ACCESS cycles.
   initial begin
      PREADY = '0; PSLVERR = '0; PRDATA = '0;
      for (int i = 0; i < NS; i++) begin
         s_waits[i] = 0; s_rdata[i] = '0; s_err[i] = 1'b0; acc_cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NS; i++) begin
            if (PSEL[i] && PENABLE) begin
               PREADY[i]             = (acc_cnt[i] >= s_waits[i]);
               PRDATA[i*32 +: 32]    = s_rdata[i];
               PSLVERR[i]            = s_err[i];
               acc_cnt[i]++;
            end else begin
               acc_cnt[i]            = 0;
               PREADY[i]             = 1'($urandom_range(0, 1));
               PRDATA[i*32 +: 32]    = $urandom;
               PSLVERR[i]            = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // One complete request: queue the expected trace, then hold busReq until busReady.
   task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] st, input int waits, input logic [31:0] rd,
                          input logic sle);
      bit          hit;
      int          idx, acc, lat;
      logic        err_x;
      logic [31:0] rd_x, off;
      logic [NS-1:0] oh;
      logic [3:0]  ps;
      hit = tb_hit(a);
      idx = hit ? int'((a - BASE) >> SHIFT) : 0;
      @(negedge clk);
      if (hit) begin
         s_waits[idx] = waits; s_rdata[idx] = rd; s_err[idx] = sle;
      end
      clear_mon();
      busReq = 1'b1; busWe = we; busAddr = a; busWData = wd; busStrb = st;
      off = a & ((32'd1 << SHIFT) - 32'd1);
      oh  = NS'(1 << idx);
      ps  = we ? st : 4'h0;
      if (!hit) begin
         exp_q.push_back(mk('0, 0, 0, '0, '0, '0, 1, 1, '0, 0));
         lat = 1;
      end else begin
         acc   = waits + 1;
         err_x = sle;
         rd_x  = we ? 32'h0 : rd;
`ifdef APB_TIMEOUT_EN
         if (waits >= TO) begin
            acc = TO; err_x = 1'b1; rd_x = '0;
         end
`endif
         exp_q.push_back(mk(oh, 0, we, off, wd, ps, 0, 0, '0, 0));
         for (int k = 0; k < acc; k++) exp_q.push_back(mk(oh, 1, we, off, wd, ps, 0, 0, '0, 0));
         exp_q.push_back(mk('0, 0, 0, '0, '0, '0, 1, err_x, rd_x, 0));
         lat = acc + 2;
      end
      exp_q.push_back(mk('0, 0, 0, '0, '0, '0, 0, 0, '0, 0));
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         // Bus inputs wander during the transfer; the bridge must ignore them.
         busAddr = $urandom; busWData = $urandom; busStrb = 4'($urandom); busWe = 1'($urandom);
         if (k == lat) busReq = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected $finish before 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; busReq = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0; busStrb = '0;
      repeat (2) @(negedge clk);
      exp_q.push_back(mk('0, 0, 0, '0, '0, '0, 0, 0, '0, 1));
      @(negedge clk);
      reset = 1'b0;

      // Zero-wait write to slave 1.
      run_txn(32'h1000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, '0, 1'b0);
      check("wr ready latency", 64'(m_ready_cyc - m_start), 64'd3);
      check("wr psel", m_psel_or, 4'b0010);
      check("wr paddr", m_paddr, 32'h004);
      check("wr penable rise", 64'(m_pen_first - m_start), 64'd2);
      check("wr err", m_err, 1'b0);

      // Read with 3 wait states from slave 2.
      run_txn(32'h1000_2000, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0);
      check("rd ready latency", 64'(m_ready_cyc - m_start), 64'd6);
      check("rd data", m_rdata, 32'h1234_5678);
      check("rd penable cycles", 64'(m_pen_cnt), 64'd4);

      // Decode miss.
      run_txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, 0, '0, 1'b0);
      check("miss ready latency", 64'(m_ready_cyc - m_start), 64'd1);
      check("miss err", m_err, 1'b1);
      check("miss rdata", m_rdata, 32'h0);
      check("miss psel", m_psel_or, 4'b0000);

      // Slave error, then a clean access to slave 0.
      run_txn(32'h1000_3010, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_0003, 1'b1);
      check("slverr err", m_err, 1'b1);
      run_txn(32'h1000_0008, 1'b0, 32'h0, 4'h0, 0, 32'h0000_00A5, 1'b0);
      check("after slverr err", m_err, 1'b0);
      check("after slverr rdata", m_rdata, 32'h0000_00A5);

      // Reset during an ACCESS wait state.
      s_waits[1] = 5; s_rdata[1] = 32'h5555_AAAA; s_err[1] = 1'b0;
      @(negedge clk);
      clear_mon();
      busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_1020;
      exp_q.push_back(mk(4'b0010, 0, 0, 32'h020, '0, 4'h0, 0, 0, '0, 0));
      exp_q.push_back(mk(4'b0010, 1, 0, 32'h020, '0, 4'h0, 0, 0, '0, 0));
      exp_q.push_back(mk(4'b0010, 1, 0, 32'h020, '0, 4'h0, 0, 0, '0, 0));
      repeat (3) @(negedge clk);
      reset = 1'b1; busReq = 1'b0;
      exp_q.push_back(mk('0, 0, 0, '0, '0, '0, 0, 0, '0, 1));
      @(negedge clk);
      reset = 1'b0;
      check("reset abort no ready", m_ready_seen, 1'b0);
      run_txn(32'h1000_1020, 1'b0, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0);
      check("post reset latency", 64'(m_ready_cyc - m_start), 64'd4);
      check("post reset rdata", m_rdata, 32'h0BAD_F00D);

      // Slave 0 never becomes ready.
`ifdef APB_TIMEOUT_EN
      run_txn(32'h1000_0010, 1'b0, 32'h0, 4'h0, 1000, 32'hAAAA_AAAA, 1'b0);
      check("timeout latency", 64'(m_ready_cyc - m_start), 64'(TO + 2));
      check("timeout err", m_err, 1'b1);
      check("timeout penable cycles", 64'(m_pen_cnt), 64'(TO));
`else
      s_waits[0] = 1000;
      @(negedge clk);
      clear_mon();
      busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_0010;
      exp_q.push_back(mk(4'b0001, 0, 0, 32'h010, '0, 4'h0, 0, 0, '0, 0));
      for (int k = 0; k < 100; k++) exp_q.push_back(mk(4'b0001, 1, 0, 32'h010, '0, 4'h0, 0, 0, '0, 0));
      repeat (101) @(negedge clk);
      check("no timeout ready", m_ready_seen, 1'b0);
      check("no timeout penable cycles", 64'(m_pen_cnt), 64'd100);
      reset = 1'b1; busReq = 1'b0;
      exp_q.push_back(mk('0, 0, 0, '0, '0, '0, 0, 0, '0, 1));
      @(negedge clk);
      reset = 1'b0;
`endif
      s_waits[0] = 0;

      // Randomized traffic: hits on every slave, misses on both sides of the window.
      for (int t = 0; t < 40; t++) begin
         int          kind;
         logic [31:0] a;
         kind = $urandom_range(0, 5);
         case (kind)
            0:       a = BASE - 32'($urandom_range(1, 65536));
            1:       a = BASE + 32'(NS << SHIFT) + 32'($urandom_range(0, 1 << 20));
            default: a = BASE + 32'($urandom_range(0, NS - 1) << SHIFT) + 32'($urandom_range(0, 4095));
         endcase
         run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 4),
                 $urandom, 1'($urandom_range(0, 3) == 0));
      end

      repeat (2) @(negedge clk);
      check("expected queue drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
